// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
//   Shared types and helpers for the reset sequencer.
//   - rst_seq_state_t : sequencer FSM state encoding
//   - MAX_CHANNELS    : widest request vector lowest_set_idx() accepts
//   - lowest_set_idx(): index of the lowest set bit (MAX_CHANNELS when none set)
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  localparam int MAX_CHANNELS = 32;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    EXTEND  = 2'd1,
    STAGGER = 2'd2,
    RUN     = 2'd3
  } rst_seq_state_t;

  // Lowest index wins: the lowest requesting channel defines how far back
  // the release sequence has to restart.
  function automatic int lowest_set_idx(input logic [MAX_CHANNELS-1:0] v);
    int idx;
    idx = MAX_CHANNELS;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// -----------------------------------------------------------------------------
// reset_sync_bit
//   SYNC_STAGES-deep flop chain bringing one asynchronous request bit into the
//   sync_clk domain. The chain clears to 0 while reset_n is low.
// Ports
//   sync_clk  in   1   clock
//   reset_n   in   1   synchronous active-low clear
//   d         in   1   asynchronous input
//   q         out  1   synchronised output
// -----------------------------------------------------------------------------
module reset_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sync_clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Multi-channel reset generator. Synchronises per-channel reset requests,
//   releases channel resets in index order with a programmable gap, and
//   re-asserts a requested channel plus every higher-index channel at once.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   HOLD    | resets from ptr upward held; waiting for all requests idle
//   EXTEND  | requests idle, counting NUM_EXTEND_CYCLES before first release
//   STAGGER | releasing channel ptr after RELEASE_GAP idle cycles
//   RUN     | every channel released
//
// Ports
//   sync_clk         in   1             sole clock
//   reset_n          in   1             synchronous active-low master reset
//   reset_req_async  in   NUM_CHANNELS  async active-high level requests
//   reset_out        out  NUM_CHANNELS  active-high per-channel resets
//   all_released     out  1             high when every reset_out bit is 0
//   cause_clr        in   1             (RESET_SEQ_CAUSE_EN) clear cause/count
//   reset_cause      out  NUM_CHANNELS  (RESET_SEQ_CAUSE_EN) sticky request edges
//   reset_count      out  8             (RESET_SEQ_CAUSE_EN) request-driven HOLD entries
//
// Build option: define RESET_SEQ_CAUSE_EN to add cause/count tracking.
// NUM_CHANNELS is limited to reset_seq_pkg::MAX_CHANNELS.
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS         = 4,
  parameter int SYNC_STAGES          = 2,
  parameter int NUM_EXTEND_CYCLES    = 4,
  parameter int RELEASE_GAP          = 2,
  parameter int NUM_OUTPUT_REGISTERS = 1
) (
  input  logic                    sync_clk,
  input  logic                    reset_n,
  input  logic [NUM_CHANNELS-1:0] reset_req_async,
`ifdef RESET_SEQ_CAUSE_EN
  input  logic                    cause_clr,
  output logic [NUM_CHANNELS-1:0] reset_cause,
  output logic [7:0]              reset_count,
`endif
  output logic [NUM_CHANNELS-1:0] reset_out,
  output logic                    all_released
);

  localparam int PTR_W     = $clog2(NUM_CHANNELS + 1);
  localparam int CNT_TOP   = (NUM_EXTEND_CYCLES > RELEASE_GAP) ? NUM_EXTEND_CYCLES : RELEASE_GAP;
  localparam int CNT_W     = (CNT_TOP > 0) ? $clog2(CNT_TOP + 1) : 1;
  localparam int EXT_LAST  = (NUM_EXTEND_CYCLES > 0) ? NUM_EXTEND_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] EXT_LAST_CNT = CNT_W'(EXT_LAST);
  localparam logic [CNT_W-1:0] GAP_CNT      = CNT_W'(RELEASE_GAP);
  localparam logic [PTR_W-1:0] PTR_DONE     = PTR_W'(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] req_s;
  logic [NUM_CHANNELS-1:0] rst_int;
  logic                    all_rel_int;
  rst_seq_state_t          state;
  logic [PTR_W-1:0]        ptr;
  logic [CNT_W-1:0]        cnt;

  // ---------------------------------------------------------------------------
  // Request synchronisers
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_sync
    reset_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .sync_clk (sync_clk),
      .reset_n  (reset_n),
      .d        (reset_req_async[g]),
      .q        (req_s[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Request decode and release helpers
  // ---------------------------------------------------------------------------
  logic [MAX_CHANNELS-1:0] req_ext;
  logic [NUM_CHANNELS-1:0] req_mask;
  logic [PTR_W-1:0]        req_idx;
  logic [NUM_CHANNELS-1:0] rel_mask;
  logic [NUM_CHANNELS-1:0] rst_after_rel;
  logic [CNT_W-1:0]        cnt_inc;

  always_comb begin
    int idx;
    req_ext                   = '0;
    req_ext[NUM_CHANNELS-1:0] = req_s;
    idx                       = lowest_set_idx(req_ext);
    req_idx                   = PTR_W'(idx);
    req_mask                  = '0;
    rel_mask                  = '0;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      // Requested channel and everything that depends on it.
      req_mask[j] = (j >= idx);
      rel_mask[j] = (PTR_W'(j) == ptr);
    end
    rst_after_rel = rst_int & ~rel_mask;
    cnt_inc       = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      state       <= HOLD;
      ptr         <= '0;
      cnt         <= '0;
      rst_int     <= '1;
      all_rel_int <= 1'b0;
    end else if (req_s != '0) begin
      // A request always beats a release scheduled for the same edge.
      rst_int     <= rst_int | req_mask;
      if (req_idx < ptr) ptr <= req_idx;
      cnt         <= '0;
      all_rel_int <= 1'b0;
      state       <= HOLD;
    end else begin
      case (state)
        HOLD: begin
          cnt <= '0;
          if (NUM_EXTEND_CYCLES == 0) begin
            rst_int     <= rst_after_rel;
            all_rel_int <= (rst_after_rel == '0);
            ptr         <= ptr + 1'b1;
            state       <= STAGGER;
          end else begin
            state <= EXTEND;
          end
        end
        EXTEND: begin
          // Compare against N-1 so the release lands N edges after HOLD exit.
          if (cnt == EXT_LAST_CNT) begin
            rst_int     <= rst_after_rel;
            all_rel_int <= (rst_after_rel == '0);
            ptr         <= ptr + 1'b1;
            cnt         <= '0;
            state       <= STAGGER;
          end else begin
            cnt <= cnt_inc;
          end
        end
        STAGGER: begin
          if (ptr == PTR_DONE) begin
            all_rel_int <= 1'b1;
            state       <= RUN;
          end else if (cnt == GAP_CNT) begin
            rst_int     <= rst_after_rel;
            all_rel_int <= (rst_after_rel == '0);
            ptr         <= ptr + 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RUN: begin
          all_rel_int <= 1'b1;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional cause / count tracking
  // ---------------------------------------------------------------------------
`ifdef RESET_SEQ_CAUSE_EN
  logic [NUM_CHANNELS-1:0] req_s_d;
  logic [NUM_CHANNELS-1:0] req_rise;
  logic                    hold_entry;

  assign req_rise   = req_s & ~req_s_d;
  // Only a transition into HOLD counts; requests arriving while already
  // holding extend the same reset episode.
  assign hold_entry = (req_s != '0) && (state != HOLD);

  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      req_s_d     <= '0;
      reset_cause <= '0;
      reset_count <= '0;
    end else begin
      req_s_d <= req_s;
      // A capture on the clearing edge survives the clear.
      if (cause_clr) begin
        reset_cause <= req_rise;
        reset_count <= hold_entry ? 8'd1 : 8'd0;
      end else begin
        reset_cause <= reset_cause | req_rise;
        if (hold_entry && (reset_count != 8'hFF)) reset_count <= reset_count + 8'd1;
      end
    end
  end
`else
  // No cause tracking in this build.
`endif

  // ---------------------------------------------------------------------------
  // Output pipeline
  // ---------------------------------------------------------------------------
  if (NUM_OUTPUT_REGISTERS == 0) begin : g_no_pipe
    assign reset_out    = rst_int;
    assign all_released = all_rel_int;
  end else begin : g_pipe
    logic [NUM_CHANNELS-1:0] rst_pipe [NUM_OUTPUT_REGISTERS];
    logic                    rel_pipe [NUM_OUTPUT_REGISTERS];

    always_ff @(posedge sync_clk) begin
      if (!reset_n) begin
        for (int s = 0; s < NUM_OUTPUT_REGISTERS; s++) begin
          rst_pipe[s] <= '1;
          rel_pipe[s] <= 1'b0;
        end
      end else begin
        rst_pipe[0] <= rst_int;
        rel_pipe[0] <= all_rel_int;
        for (int s = 1; s < NUM_OUTPUT_REGISTERS; s++) begin
          rst_pipe[s] <= rst_pipe[s-1];
          rel_pipe[s] <= rel_pipe[s-1];
        end
      end
    end

    assign reset_out    = rst_pipe[NUM_OUTPUT_REGISTERS-1];
    assign all_released = rel_pipe[NUM_OUTPUT_REGISTERS-1];
  end

endmodule
